imem_prog_loader: RTL and testbench

// - Byte-stream program loader; the write-side of the instruction memory. Replaces hierarchical imem pokes.
// - Receives a framed program over a byte valid/ready channel, packs bytes into little-endian 32-bit words and drives the imem write port.
// - Holds the processor in reset until a frame passes its checksum, then releases the core to fetch from address 0.

---
 rtl/imem_prog_loader_if.sv | 37 +++
 rtl/imem_prog_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_prog_loader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_prog_loader_if.sv
// ============================================================================
// Module      : imem_prog_loader_if
// Description : Byte receive channel plus instruction-memory write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_prog_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_waddr;
    logic [31:0]           imem_wdata;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/imem_prog_loader.sv
// ============================================================================
// Module      : imem_prog_loader
// Description : Framed byte-stream loader that packs little-endian words into
//               imem and releases the core once the frame checksum matches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_prog_loader #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] HDR_BYTE   = 8'hA5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    imem_prog_loader_if.slave  bus,
    output logic               core_rst,
    output logic               load_done,
    output logic               load_err,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic                  r_rx_ready;
    logic [7:0]            r_count,      w_count_nxt;
    logic [1:0]            r_byte_idx,   w_byte_idx_nxt;
    logic [23:0]           r_word_buf,   w_word_buf_nxt;
    logic [7:0]            r_xor,        w_xor_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,       w_addr_nxt;
    logic                  r_we,         w_we_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr,      w_waddr_nxt;
    logic [31:0]           r_wdata,      w_wdata_nxt;
    logic                  r_core_rst,   w_core_rst_nxt;
    logic                  r_load_done,  w_load_done_nxt;
    logic                  r_load_err,   w_load_err_nxt;

    logic                  w_fire;
    logic                  w_is_hdr;

    assign w_fire   = bus.rx_valid & r_rx_ready;
    assign w_is_hdr = (bus.rx_data == HDR_BYTE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rx_ready  <= 1'b0;
            r_count     <= 8'd0;
            r_byte_idx  <= 2'd0;
            r_word_buf  <= 24'd0;
            r_xor       <= 8'd0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= 32'd0;
            r_core_rst  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rx_ready  <= 1'b1;
            r_count     <= w_count_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_word_buf  <= w_word_buf_nxt;
            r_xor       <= w_xor_nxt;
            r_addr      <= w_addr_nxt;
            r_we        <= w_we_nxt;
            r_waddr     <= w_waddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_core_rst  <= w_core_rst_nxt;
            r_load_done <= w_load_done_nxt;
            r_load_err  <= w_load_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_byte_idx_nxt  = r_byte_idx;
        w_word_buf_nxt  = r_word_buf;
        w_xor_nxt       = r_xor;
        w_addr_nxt      = r_addr;
        w_we_nxt        = 1'b0;
        w_waddr_nxt     = r_waddr;
        w_wdata_nxt     = r_wdata;
        w_core_rst_nxt  = r_core_rst;
        w_load_done_nxt = 1'b0;
        w_load_err_nxt  = r_load_err;

        case (r_state)
            // A header while running is a reload: hold the core and start over.
            S_IDLE, S_RUN: begin
                if (w_fire && w_is_hdr) begin
                    w_state_nxt    = S_COUNT;
                    w_load_err_nxt = 1'b0;
                    w_xor_nxt      = 8'd0;
                    w_addr_nxt     = '0;
                    w_byte_idx_nxt = 2'd0;
                    w_core_rst_nxt = 1'b1;
                end
            end

            S_COUNT: begin
                if (w_fire) begin
                    w_count_nxt    = bus.rx_data;
                    w_byte_idx_nxt = 2'd0;
                    w_state_nxt    = (bus.rx_data == 8'd0) ? S_CHECK : S_DATA;
                end
            end

            S_DATA: begin
                if (w_fire) begin
                    w_xor_nxt      = r_xor ^ bus.rx_data;
                    w_byte_idx_nxt = r_byte_idx + 2'd1;
                    case (r_byte_idx)
                        2'd0: w_word_buf_nxt[7:0]   = bus.rx_data;
                        2'd1: w_word_buf_nxt[15:8]  = bus.rx_data;
                        2'd2: w_word_buf_nxt[23:16] = bus.rx_data;
                        default: begin
                            w_we_nxt    = 1'b1;
                            w_waddr_nxt = r_addr;
                            w_wdata_nxt = {bus.rx_data, r_word_buf};
                            w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
                            w_count_nxt = r_count - 8'd1;
                            if (r_count == 8'd1) begin
                                w_state_nxt = S_CHECK;
                            end
                        end
                    endcase
                end
            end

            S_CHECK: begin
                if (w_fire) begin
                    if (bus.rx_data == r_xor) begin
                        w_state_nxt     = S_RUN;
                        w_core_rst_nxt  = 1'b0;
                        w_load_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = S_IDLE;
                        w_load_err_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.rx_ready   = r_rx_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_waddr = r_waddr;
    assign bus.imem_wdata = r_wdata;
    assign core_rst       = r_core_rst;
    assign load_done      = r_load_done;
    assign load_err       = r_load_err;
    assign busy           = (r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_CHECK);

endmodule

`default_nettype wire

// File: tb/tb_imem_prog_loader.sv
// ============================================================================
// Module      : tb_imem_prog_loader
// Description : Scoreboard bench for imem_prog_loader (directed frames).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_prog_loader;

    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    logic core_rst, load_done, load_err, busy;

    imem_prog_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_prog_loader #(.ADDR_WIDTH(AW), .HDR_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .core_rst  (core_rst),
        .load_done (load_done),
        .load_err  (load_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_done;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } ev_t;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] exp;
        logic [15:0] step;
    } probe_t;

    ev_t    exp_q[$];
    probe_t probe_q[$];
    int     n_vec  = 0;
    int     n_miss = 0;
    int     step   = 0;
    event   probe_ev;

    function automatic logic [31:0] probe_val(input logic [3:0] sel);
        case (sel)
            4'd0:    return {31'd0, core_rst};
            4'd1:    return {31'd0, load_err};
            4'd2:    return {31'd0, busy};
            4'd3:    return {31'd0, bus.rx_ready};
            4'd4:    return {31'd0, bus.imem_we};
            4'd5:    return {31'd0, load_done};
            default: return 32'(exp_q.size());
        endcase
    endfunction

    function automatic string probe_name(input logic [3:0] sel);
        case (sel)
            4'd0:    return "core_rst";
            4'd1:    return "load_err";
            4'd2:    return "busy";
            4'd3:    return "rx_ready";
            4'd4:    return "imem_we";
            4'd5:    return "load_done";
            default: return "pending_events";
        endcase
    endfunction

    // Monitor: status probes on request, write/done events on every falling edge.
    initial begin
        probe_t p;
        ev_t    e;
        logic [31:0] act;
        forever begin
            @(negedge clk or probe_ev);
            while (probe_q.size() != 0) begin
                p   = probe_q.pop_front();
                act = probe_val(p.sel);
                n_vec++;
                if (act !== p.exp) begin
                    n_miss++;
                    $display("FAIL %s step %0d: got %0h expected %0h", probe_name(p.sel), p.step, act, p.exp);
                end
            end
            if (clk === 1'b0) begin
                if (bus.imem_we === 1'b1) begin
                    n_vec++;
                    if (exp_q.size() == 0 || exp_q[0].is_done) begin
                        n_miss++;
                        $display("FAIL write: unexpected write addr %0h data %08h", bus.imem_waddr, bus.imem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.imem_waddr !== e.addr || bus.imem_wdata !== e.data) begin
                            n_miss++;
                            $display("FAIL write: got addr %0h data %08h expected addr %0h data %08h",
                                     bus.imem_waddr, bus.imem_wdata, e.addr, e.data);
                        end
                    end
                end
                if (load_done === 1'b1) begin
                    n_vec++;
                    if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                        n_miss++;
                        $display("FAIL load_done: got pulse, expected %0s",
                                 (exp_q.size() == 0) ? "nothing" : "a write first");
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic probe(input logic [3:0] sel, input logic [31:0] e);
        probe_t p;
        step++;
        p.sel  = sel;
        p.exp  = e;
        p.step = 16'(step);
        probe_q.push_back(p);
        ->probe_ev;
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
        ev_t e;
        e.is_done = 1'b0;
        e.addr    = a;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_done();
        ev_t e;
        e.is_done = 1'b1;
        e.addr    = '0;
        e.data    = 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[7:0]);
        send(w[15:8]);
        send(w[23:16]);
        send(w[31:24]);
    endtask

    logic [31:0] prog [5];
    logic [31:0] ww;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        prog[0] = 32'h06400293;
        prog[1] = 32'h00500023;
        prog[2] = 32'h00000303;
        prog[3] = 32'h001303B3;
        prog[4] = 32'h40538433;

        rst = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(posedge clk);
        #1;
        probe(0, 1); probe(3, 0); probe(4, 0); probe(1, 0); probe(2, 0); probe(5, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        probe(3, 1); probe(2, 0);

        // Good load, checksum A3
        for (int i = 0; i < 5; i++) expect_write(AW'(i), prog[i]);
        expect_done();
        send(8'hA5);
        probe(2, 1);
        send(8'h05);
        for (int i = 0; i < 5; i++) send_word(prog[i]);
        send(8'hA3);
        probe(0, 0); probe(1, 0); probe(2, 0);

        // Same frame, bad checksum A2
        for (int i = 0; i < 5; i++) expect_write(AW'(i), prog[i]);
        send(8'hA5);
        probe(0, 1);
        send(8'h05);
        for (int i = 0; i < 5; i++) send_word(prog[i]);
        send(8'hA2);
        probe(1, 1); probe(0, 1); probe(2, 0);

        // Garbage in IDLE, then an empty frame
        send(8'h00); send(8'hFF); send(8'h12);
        probe(2, 0); probe(1, 1);
        send(8'hA5);
        probe(1, 0); probe(2, 1);
        expect_done();
        send(8'h00);
        probe(2, 1);
        send(8'h00);
        probe(0, 0); probe(2, 0);

        // Reload while running; payload byte equal to nothing special
        send(8'hA5);
        probe(0, 1);
        expect_write(AW'(0), 32'h00000013);
        expect_done();
        send(8'h01);
        send_word(32'h00000013);
        send(8'h13);
        probe(0, 0);

        // Address wrap: 10 words into 8-deep memory, word i = {30,20,10,i}; XOR = 0^1^..^9 = 01
        for (int i = 0; i < 10; i++) expect_write(AW'(i % 8), {24'h302010, 8'(i)});
        expect_done();
        send(8'hA5);
        send(8'h0A);
        for (int i = 0; i < 10; i++) begin
            ww = {24'h302010, 8'(i)};
            send_word(ww);
        end
        send(8'h01);
        probe(0, 0);

        // HDR value inside payload is data: word A5A5A5A5 with XOR 00
        expect_write(AW'(0), 32'hA5A5A5A5);
        expect_done();
        send(8'hA5); send(8'h01);
        send_word(32'hA5A5A5A5);
        send(8'h00);
        probe(0, 0);

        // Asynchronous reset mid-frame after 6 payload bytes
        expect_write(AW'(0), 32'h44332211);
        send(8'hA5); send(8'h02);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
        #1;
        rst = 1'b0;
        #1;
        probe(0, 1); probe(4, 0); probe(1, 0); probe(2, 0); probe(3, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        probe(3, 1);

        // Fresh frame restarts at address 0; XOR DD^CC^BB^AA = 00
        expect_write(AW'(0), 32'hAABBCCDD);
        expect_done();
        send(8'hA5); send(8'h01);
        send_word(32'hAABBCCDD);
        send(8'h00);
        probe(0, 0);

        repeat (4) @(posedge clk);
        #1;
        probe(6, 0);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
